hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Central hazard and stall scheduler for the 5-stage RISC-V pipeline.
//  - Drives stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  - Drives the EX-stage forwarding selects.
//  - Runs a wait-state FSM that freezes the pipeline while a multi-cycle data-memory access completes.
//  - Keeps a saturating stall-cycle counter.
// PARAMETERS
//  TIMEOUT  200  max WAIT cycles before MemErr; must be < 2**WAIT_W
//  WAIT_W   8    width of the wait-state counter
//  CNT_W    16   width of StallCnt
// PORTS
//  clk          in   1       pipeline clock; all state updates on posedge
//  reset        in   1       asynchronous reset, active-low (asserted when 0)
//  Rs1D,Rs2D    in   5       source regs of instruction in ID
//  Rs1E,Rs2E    in   5       source regs of instruction in EX
//  RdE          in   5       dest reg in EX
//  ResultSrcE0  in   1       1 = instruction in EX is a load
//  PCSrcE       in   1       1 = taken branch/jump resolved in EX
//  RdM          in   5       dest reg in MEM
//  RegWriteM    in   1       MEM instruction writes regfile
//  RdW          in   5       dest reg in WB
//  RegWriteW    in   1       WB instruction writes regfile
//  MemReqM      in   1       MEM instruction accesses data memory (held while stalled)
//  MemReadyM    in   1       data memory completes access this cycle
//  StallF       out  1       hold PC
//  StallD       out  1       hold IF/ID
//  StallE       out  1       hold ID/EX
//  StallM       out  1       hold EX/MEM
//  FlushD       out  1       clear IF/ID
//  FlushE       out  1       clear ID/EX
//  FlushW       out  1       load bubble into MEM/WB
//  ForwardAE    out  2       src A select: 00 regfile, 01 WB result, 10 MEM ALU result
//  ForwardBE    out  2       src B select: same encoding as ForwardAE
//  MemErr       out  1       sticky memory timeout flag
//  StallCnt     out  CNT_W   saturating count of cycles with StallF=1
// BEHAVIOUR
//  Reset (reset=0, async)
//   - FSM goes to IDLE; wait counter, StallCnt and MemErr go to 0.
//   - All stall/flush outputs are forced 0 and ForwardAE/BE are forced 00 while reset=0.
//  Forwarding (combinational)
//   - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
//   - Otherwise 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
//   - Otherwise 00. MEM has priority over WB.
//   - ForwardBE follows the same rules with Rs2E.
//  Load-use
//   - lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
//  Memory FSM
//   - IDLE: if MemReqM & ~MemReadyM, go to WAIT and set the wait counter to 1.
//     Otherwise stay in IDLE; a same-cycle ready is a zero-wait access with no stall.
//   - WAIT: if MemReadyM, go to IDLE; this completion cycle is not stalled.
//     Else if counter==TIMEOUT, go to ERR and set MemErr=1.
//     Else increment the counter.
//   - ERR: terminal. Pipeline stays frozen until reset.
//  memStall = (IDLE & MemReqM & ~MemReadyM) | (WAIT & ~MemReadyM) | ERR.
//  Priority
//   - If memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
//     PCSrcE and lwStall are ignored; they are re-evaluated after release because EX is held.
//   - Else: StallF=StallD=lwStall; StallE=StallM=FlushW=0; FlushD=PCSrcE; FlushE=lwStall|PCSrcE.
//  StallCnt increments on every posedge with StallF=1 and saturates at 2**CNT_W-1.
//  All stall/flush/forward outputs are combinational from the inputs and the FSM state; there is no added latency.
// TESTING
//  - Load-use: ResultSrcE0=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for 1 cycle, StallCnt=1. Same with RdE=0 -> no stall.
//  - Branch: PCSrcE=1, no load -> FlushD=FlushE=1, all stalls 0.
//  - Mem wait: MemReqM=1, MemReadyM low for 3 cycles then high -> StallF..StallM=1 and FlushW=1 for exactly 3 cycles; FSM back in IDLE; StallCnt=3.
//  - Zero-wait: MemReqM=1 with MemReadyM=1 in the same cycle -> no stall, FSM stays IDLE.
//  - Timeout: TIMEOUT=4, MemReadyM never high -> MemErr=1 when the counter reaches 4; stalls held indefinitely; reset=0 mid-ERR clears everything asynchronously.
//  - Overlap and forwarding:
//    - memStall with PCSrcE=1 and lwStall=1 -> no flushes during the stall; FlushD=FlushE=1 on the release cycle.
//    - Rs1E=3, RdM=RdW=3, RegWriteM=RegWriteW=1 -> ForwardAE=10.
//    - Rs2E=0 with RdW=0 -> ForwardBE=00.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
// The datapath side (master) drives hazard sources; the controller (slave)
// returns stall, flush, forwarding and status.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic             ResultSrcE0;
  logic             PCSrcE;
  logic [4:0]       RdM;
  logic             RegWriteM;
  logic [4:0]       RdW;
  logic             RegWriteW;
  logic             MemReqM;
  logic             MemReadyM;

  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemErr, StallCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemErr, StallCnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall scheduler for the 5-stage pipeline: EX forwarding selects,
// load-use interlock, branch flush, and a wait-state FSM that freezes the
// whole pipeline while a multi-cycle data-memory access is outstanding.
// All control outputs are combinational from inputs and FSM state.
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 200,
  parameter int WAIT_W  = 8,
  parameter int CNT_W   = 16
) (
  input logic            clk,
  input logic            reset,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                mem_err;
  logic [CNT_W-1:0]    stall_cnt;

  logic                timeout_hit;
  logic                lw_stall;
  logic                mem_stall;
  logic                stall_f;
  logic                stall_e;
  logic                flush_d;
  logic                flush_e;
  logic                flush_w;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;

  // MEM result wins over WB result; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT));

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Wait-state counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.MemReqM && !bus.MemReadyM) wait_cnt <= WAIT_W'(1);
        S_WAIT: if (!bus.MemReadyM && !timeout_hit) wait_cnt <= wait_cnt + WAIT_W'(1);
        default: ;
      endcase
      if ((state == S_WAIT) && (state_nxt == S_ERR))
        mem_err <= 1'b1;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (stall_f)
      stall_cnt <= sat_inc(stall_cnt);
  end

  // Next-state logic for the memory wait FSM; ERR is left only by reset.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.MemReqM && !bus.MemReadyM) state_nxt = S_WAIT;
      S_WAIT:  if (bus.MemReadyM)                 state_nxt = S_IDLE;
               else if (timeout_hit)              state_nxt = S_ERR;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stall/flush/forward outputs; a memory freeze overrides load-use and
  // branch handling, which re-evaluate on release since EX is held.
  always_comb begin
    lw_stall  = bus.ResultSrcE0 && (bus.RdE != 5'd0) &&
                ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
    mem_stall = ((state == S_IDLE) && bus.MemReqM && !bus.MemReadyM) ||
                ((state == S_WAIT) && !bus.MemReadyM) ||
                (state == S_ERR);
    fwd_a     = fwd_sel(bus.Rs1E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
    fwd_b     = fwd_sel(bus.Rs2E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_e = 1'b1;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b1;
    end else begin
      stall_f = lw_stall;
      stall_e = 1'b0;
      flush_d = bus.PCSrcE;
      flush_e = lw_stall || bus.PCSrcE;
      flush_w = 1'b0;
    end
    if (!reset) begin
      stall_f = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      fwd_a   = 2'b00;
      fwd_b   = 2'b00;
    end
  end

  assign bus.StallF    = stall_f;
  assign bus.StallD    = stall_f;
  assign bus.StallE    = stall_e;
  assign bus.StallM    = stall_e;
  assign bus.FlushD    = flush_d;
  assign bus.FlushE    = flush_e;
  assign bus.FlushW    = flush_w;
  assign bus.ForwardAE = fwd_a;
  assign bus.ForwardBE = fwd_b;
  assign bus.MemErr    = mem_err;
  assign bus.StallCnt  = stall_cnt;

endmodule
